// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection
module id_ex_stage #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ifid_valid,
    input  logic [4:0]        ifid_rn,
    input  logic [4:0]        ifid_rm,
    input  logic              ifid_uses_rm,
    input  logic [4:0]        ifid_rd,
    input  logic [DATA_W-1:0] ifid_opa,
    input  logic [DATA_W-1:0] ifid_opb,
    input  logic [DATA_W-1:0] ifid_imm,
    input  logic              ifid_regwrite,
    input  logic              ifid_memread,
    input  logic              ifid_memwrite,
    input  logic              ifid_memtoreg,
    input  logic              ifid_alusrc,
    input  logic [2:0]        ifid_aluop,
    input  logic              flush,
    input  logic              hold,
    output logic              idex_valid,
    output logic [4:0]        idex_rn,
    output logic [4:0]        idex_rm,
    output logic [4:0]        idex_rd,
    output logic [DATA_W-1:0] idex_opa,
    output logic [DATA_W-1:0] idex_opb,
    output logic [DATA_W-1:0] idex_imm,
    output logic              idex_regwrite,
    output logic              idex_memread,
    output logic              idex_memwrite,
    output logic              idex_memtoreg,
    output logic              idex_alusrc,
    output logic [2:0]        idex_aluop,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [4:0] XZR = 5'd31;

    logic lu_hazard;
    logic advance;
    logic take_instr;
    logic count_bubble;

    // Load in EX whose destination is read by the instruction in ID; XZR never aliases
    always_comb begin
        lu_hazard = idex_valid & idex_memread & (idex_rd != XZR) & ifid_valid &
                    ((idex_rd == ifid_rn) | (ifid_uses_rm & (idex_rd == ifid_rm)));
        // Flush squashes the dependent instruction, so it cannot also stall
        stall_pc     = (lu_hazard & ~flush) | hold;
        stall_ifid   = (lu_hazard & ~flush) | hold;
        // Flush beats hold; hold freezes everything otherwise
        advance      = flush | ~hold;
        take_instr   = ~flush & ~hold & ~lu_hazard & ifid_valid;
        count_bubble = ~flush & ~hold & lu_hazard;
    end

    // Pipeline register: either capture the ID instruction or insert an all-zero bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_valid    <= 1'b0;
            idex_rn       <= 5'd0;
            idex_rm       <= 5'd0;
            idex_rd       <= 5'd0;
            idex_opa      <= '0;
            idex_opb      <= '0;
            idex_imm      <= '0;
            idex_regwrite <= 1'b0;
            idex_memread  <= 1'b0;
            idex_memwrite <= 1'b0;
            idex_memtoreg <= 1'b0;
            idex_alusrc   <= 1'b0;
            idex_aluop    <= 3'd0;
        end else if (advance) begin
            if (take_instr) begin
                idex_valid    <= 1'b1;
                idex_rn       <= ifid_rn;
                idex_rm       <= ifid_rm;
                idex_rd       <= ifid_rd;
                idex_opa      <= ifid_opa;
                idex_opb      <= ifid_opb;
                idex_imm      <= ifid_imm;
                idex_regwrite <= ifid_regwrite;
                idex_memread  <= ifid_memread;
                idex_memwrite <= ifid_memwrite;
                idex_memtoreg <= ifid_memtoreg;
                idex_alusrc   <= ifid_alusrc;
                idex_aluop    <= ifid_aluop;
            end else begin
                idex_valid    <= 1'b0;
                idex_rn       <= 5'd0;
                idex_rm       <= 5'd0;
                idex_rd       <= 5'd0;
                idex_opa      <= '0;
                idex_opb      <= '0;
                idex_imm      <= '0;
                idex_regwrite <= 1'b0;
                idex_memread  <= 1'b0;
                idex_memwrite <= 1'b0;
                idex_memtoreg <= 1'b0;
                idex_alusrc   <= 1'b0;
                idex_aluop    <= 3'd0;
            end
        end
    end

    // Saturating count of load-use bubbles actually inserted
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (count_bubble && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed testbench for id_ex_stage
module tb_id_ex_stage;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              ifid_valid;
    logic [4:0]        ifid_rn, ifid_rm, ifid_rd;
    logic              ifid_uses_rm;
    logic [DATA_W-1:0] ifid_opa, ifid_opb, ifid_imm;
    logic              ifid_regwrite, ifid_memread, ifid_memwrite, ifid_memtoreg, ifid_alusrc;
    logic [2:0]        ifid_aluop;
    logic              flush, hold;
    logic              idex_valid;
    logic [4:0]        idex_rn, idex_rm, idex_rd;
    logic [DATA_W-1:0] idex_opa, idex_opb, idex_imm;
    logic              idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg, idex_alusrc;
    logic [2:0]        idex_aluop;
    logic              stall_pc, stall_ifid;
    logic [CNT_W-1:0]  stall_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .ifid_valid(ifid_valid), .ifid_rn(ifid_rn), .ifid_rm(ifid_rm),
        .ifid_uses_rm(ifid_uses_rm), .ifid_rd(ifid_rd),
        .ifid_opa(ifid_opa), .ifid_opb(ifid_opb), .ifid_imm(ifid_imm),
        .ifid_regwrite(ifid_regwrite), .ifid_memread(ifid_memread),
        .ifid_memwrite(ifid_memwrite), .ifid_memtoreg(ifid_memtoreg),
        .ifid_alusrc(ifid_alusrc), .ifid_aluop(ifid_aluop),
        .flush(flush), .hold(hold),
        .idex_valid(idex_valid), .idex_rn(idex_rn), .idex_rm(idex_rm), .idex_rd(idex_rd),
        .idex_opa(idex_opa), .idex_opb(idex_opb), .idex_imm(idex_imm),
        .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
        .idex_memwrite(idex_memwrite), .idex_memtoreg(idex_memtoreg),
        .idex_alusrc(idex_alusrc), .idex_aluop(idex_aluop),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ctl = {regwrite, memread, memwrite, memtoreg, alusrc}
    task automatic set_ins(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                           input logic urm, input logic [4:0] rd,
                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] im,
                           input logic [4:0] ctl, input logic [2:0] op);
        ifid_valid    = v;
        ifid_rn       = rn;
        ifid_rm       = rm;
        ifid_uses_rm  = urm;
        ifid_rd       = rd;
        ifid_opa      = a;
        ifid_opb      = b;
        ifid_imm      = im;
        ifid_regwrite = ctl[4];
        ifid_memread  = ctl[3];
        ifid_memwrite = ctl[2];
        ifid_memtoreg = ctl[1];
        ifid_alusrc   = ctl[0];
        ifid_aluop    = op;
    endtask

    task automatic bump_cnt();
        if (exp_cnt < 3) exp_cnt = exp_cnt + 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        hold  = 1'b0;
        set_ins(1'b1, 5'($urandom), 5'($urandom), 1'b1, 5'($urandom),
                {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                5'b11011, 3'($urandom));
        step();
        step();
        checks++; if (idex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", idex_valid); end
        checks++; if (idex_rd !== 5'd0 || idex_rn !== 5'd0 || idex_rm !== 5'd0) begin errors++; $display("FAIL reset_regs got %0d/%0d/%0d exp 0", idex_rd, idex_rn, idex_rm); end
        checks++; if (idex_opa !== 64'd0 || idex_opb !== 64'd0 || idex_imm !== 64'd0) begin errors++; $display("FAIL reset_data got %h/%h/%h exp 0", idex_opa, idex_opb, idex_imm); end
        checks++; if ({idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg, idex_alusrc, idex_aluop} !== 8'd0) begin errors++; $display("FAIL reset_ctl nonzero controls"); end
        checks++; if (stall_count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", stall_count); end
        checks++; if (stall_pc !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", stall_pc); end
        set_ins(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 64'd0, 64'd0, 64'd0, 5'b00000, 3'd0);
        reset = 1'b0;
        exp_cnt = 0;
        step();
    endtask

    task automatic test_pass_through();
        set_ins(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 64'd5, 64'd7, 64'd0, 5'b10000, 3'b010);
        #1;
        checks++; if (stall_pc !== 1'b0) begin errors++; $display("FAIL pass_stall_pre got %0b exp 0", stall_pc); end
        step();
        checks++; if (idex_valid !== 1'b1 || idex_rd !== 5'd3) begin errors++; $display("FAIL pass_rd got v=%0b rd=%0d exp v=1 rd=3", idex_valid, idex_rd); end
        checks++; if (idex_opa !== 64'd5 || idex_opb !== 64'd7) begin errors++; $display("FAIL pass_ops got %0d/%0d exp 5/7", idex_opa, idex_opb); end
        checks++; if (idex_regwrite !== 1'b1 || idex_aluop !== 3'b010 || idex_memread !== 1'b0) begin errors++; $display("FAIL pass_ctl got rw=%0b op=%0d mr=%0b exp 1/2/0", idex_regwrite, idex_aluop, idex_memread); end
        checks++; if (stall_pc !== 1'b0) begin errors++; $display("FAIL pass_stall got %0b exp 0", stall_pc); end
    endtask

    task automatic test_load_use_rm();
        set_ins(1'b1, 5'd2, 5'd0, 1'b0, 5'd4, 64'd100, 64'd0, 64'd8, 5'b11011, 3'b010);
        step();
        set_ins(1'b1, 5'd1, 5'd4, 1'b1, 5'd5, 64'd11, 64'd22, 64'd0, 5'b10000, 3'b010);
        #1;
        checks++; if (stall_pc !== 1'b1 || stall_ifid !== 1'b1) begin errors++; $display("FAIL lu_stall got pc=%0b ifid=%0b exp 1/1", stall_pc, stall_ifid); end
        step();
        bump_cnt();
        checks++; if (idex_valid !== 1'b0 || {idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg, idex_alusrc, idex_aluop} !== 8'd0) begin errors++; $display("FAIL lu_bubble got valid=%0b exp bubble", idex_valid); end
        checks++; if (stall_count !== 2'(exp_cnt)) begin errors++; $display("FAIL lu_count got %0d exp %0d", stall_count, exp_cnt); end
        checks++; if (stall_pc !== 1'b0) begin errors++; $display("FAIL lu_one_cycle got %0b exp 0", stall_pc); end
        step();
        checks++; if (idex_valid !== 1'b1 || idex_rm !== 5'd4 || idex_rd !== 5'd5) begin errors++; $display("FAIL lu_release got v=%0b rm=%0d rd=%0d exp 1/4/5", idex_valid, idex_rm, idex_rd); end
    endtask

    task automatic test_no_false_hazard();
        set_ins(1'b1, 5'd2, 5'd0, 1'b0, 5'd31, 64'd0, 64'd0, 64'd8, 5'b11011, 3'b010);
        step();
        set_ins(1'b1, 5'd31, 5'd31, 1'b1, 5'd6, 64'd0, 64'd0, 64'd0, 5'b10000, 3'b010);
        #1;
        checks++; if (stall_pc !== 1'b0) begin errors++; $display("FAIL xzr_stall got %0b exp 0", stall_pc); end
        set_ins(1'b1, 5'd2, 5'd0, 1'b0, 5'd4, 64'd0, 64'd0, 64'd8, 5'b11011, 3'b010);
        step();
        set_ins(1'b1, 5'd1, 5'd4, 1'b0, 5'd7, 64'd0, 64'd0, 64'd9, 5'b10001, 3'b010);
        #1;
        checks++; if (stall_pc !== 1'b0) begin errors++; $display("FAIL no_rm_stall got %0b exp 0", stall_pc); end
        step();
        checks++; if (idex_valid !== 1'b1 || idex_rd !== 5'd7 || idex_imm !== 64'd9) begin errors++; $display("FAIL no_rm_pass got v=%0b rd=%0d exp 1/7", idex_valid, idex_rd); end
        checks++; if (stall_count !== 2'(exp_cnt)) begin errors++; $display("FAIL no_rm_count got %0d exp %0d", stall_count, exp_cnt); end
    endtask

    task automatic test_flush();
        set_ins(1'b1, 5'd2, 5'd0, 1'b0, 5'd6, 64'd0, 64'd0, 64'd8, 5'b11011, 3'b010);
        step();
        set_ins(1'b1, 5'd6, 5'd1, 1'b1, 5'd7, 64'd0, 64'd0, 64'd0, 5'b10000, 3'b010);
        flush = 1'b1;
        #1;
        checks++; if (stall_pc !== 1'b0 || stall_ifid !== 1'b0) begin errors++; $display("FAIL flush_stall got %0b/%0b exp 0/0", stall_pc, stall_ifid); end
        step();
        flush = 1'b0;
        checks++; if (idex_valid !== 1'b0 || idex_memread !== 1'b0 || idex_regwrite !== 1'b0) begin errors++; $display("FAIL flush_bubble got valid=%0b exp 0", idex_valid); end
        checks++; if (stall_count !== 2'(exp_cnt)) begin errors++; $display("FAIL flush_count got %0d exp %0d", stall_count, exp_cnt); end
    endtask

    task automatic test_hold();
        set_ins(1'b1, 5'd9, 5'd10, 1'b1, 5'd11, 64'h1234_5678_9abc_def0, 64'd3, 64'd0, 5'b10000, 3'b110);
        step();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_ins(1'b1, 5'(i), 5'(i + 1), 1'b1, 5'(i + 20), 64'(i), 64'(i), 64'(i), 5'b11111, 3'b001);
            #1;
            checks++; if (stall_pc !== 1'b1 || stall_ifid !== 1'b1) begin errors++; $display("FAIL hold_stall[%0d] got %0b/%0b exp 1/1", i, stall_pc, stall_ifid); end
            step();
            checks++; if (idex_rd !== 5'd11 || idex_opa !== 64'h1234_5678_9abc_def0 || idex_aluop !== 3'b110 || idex_valid !== 1'b1) begin errors++; $display("FAIL hold_keep[%0d] got rd=%0d opa=%h exp 11/123456789abcdef0", i, idex_rd, idex_opa); end
        end
        flush = 1'b1;
        #1;
        checks++; if (stall_pc !== 1'b1) begin errors++; $display("FAIL flush_hold_stall got %0b exp 1", stall_pc); end
        step();
        checks++; if (idex_valid !== 1'b0 || idex_rd !== 5'd0) begin errors++; $display("FAIL flush_hold_bubble got v=%0b rd=%0d exp 0/0", idex_valid, idex_rd); end
        flush = 1'b0;
        hold  = 1'b0;
    endtask

    task automatic test_back_to_back();
        set_ins(1'b1, 5'd1, 5'd0, 1'b0, 5'd8, 64'd0, 64'd0, 64'd0, 5'b11011, 3'b010);
        step();
        set_ins(1'b1, 5'd8, 5'd0, 1'b0, 5'd8, 64'd0, 64'd0, 64'd0, 5'b11011, 3'b010);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (stall_pc !== 1'b1) begin errors++; $display("FAIL b2b_stall[%0d] got %0b exp 1", i, stall_pc); end
            step();
            bump_cnt();
            checks++; if (idex_valid !== 1'b0 || stall_count !== 2'(exp_cnt)) begin errors++; $display("FAIL b2b_bubble[%0d] got v=%0b cnt=%0d exp 0/%0d", i, idex_valid, stall_count, exp_cnt); end
            step();
            checks++; if (idex_valid !== 1'b1 || idex_memread !== 1'b1 || idex_rn !== 5'd8) begin errors++; $display("FAIL b2b_load[%0d] got v=%0b mr=%0b exp 1/1", i, idex_valid, idex_memread); end
        end
        checks++; if (stall_count !== 2'd3) begin errors++; $display("FAIL sat_count got %0d exp 3", stall_count); end
    endtask

    task automatic test_reset_in_stall();
        #1;
        checks++; if (stall_pc !== 1'b1) begin errors++; $display("FAIL rst_stall_pre got %0b exp 1", stall_pc); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++; if (idex_valid !== 1'b0 || stall_pc !== 1'b0 || stall_count !== 2'd0) begin errors++; $display("FAIL rst_stall got v=%0b stall=%0b cnt=%0d exp 0/0/0", idex_valid, stall_pc, stall_count); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_load_use_rm();
        test_no_false_hazard();
        test_flush();
        test_hold();
        test_back_to_back();
        test_reset_in_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage 64-bit pipeline, combined with load-use hazard detection.
- Captures decoded operands, register numbers and control bits from ID.
- Presents idex_rn / idex_rm / idex_rd to the EX-stage forwarding unit.
- Inserts a one-cycle bubble and freezes PC/IF-ID when an EX-stage load feeds the instruction in ID; squashes on branch flush.

Parameters:
- DATA_W, 64, operand/immediate width
- CNT_W, 16, stall-event counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ifid_valid  in  1  ID holds a real instruction
- ifid_rn  in  5  first source register
- ifid_rm  in  5  second source register
- ifid_uses_rm  in  1  instruction reads rm (0 for I-type/D-load)
- ifid_rd  in  5  destination register
- ifid_opa  in  DATA_W  register-file read data for rn
- ifid_opb  in  DATA_W  register-file read data for rm
- ifid_imm  in  DATA_W  sign-extended immediate
- ifid_regwrite, ifid_memread, ifid_memwrite, ifid_memtoreg, ifid_alusrc  in  1 each  decoded controls
- ifid_aluop  in  3  ALU operation
- flush  in  1  branch taken in EX/MEM: squash ID and ID/EX
- hold  in  1  downstream freeze (data memory busy)
- idex_valid, idex_rn, idex_rm, idex_rd, idex_opa, idex_opb, idex_imm, idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg, idex_alusrc, idex_aluop  out  matching widths  registered copies
- stall_pc  out  1  PC must not advance
- stall_ifid  out  1  IF/ID must hold
- stall_count  out  CNT_W  saturating count of load-use bubbles

Behaviour:
- Reset (synchronous, sampled on posedge clk): all idex_* outputs = 0 (valid=0, controls=0, registers=5'd0, data=0); stall_count = 0. Reset overrides every other input.
- Hazard (combinational):
  - lu_hazard = idex_valid & idex_memread & (idex_rd != 31) & ifid_valid & ((idex_rd == ifid_rn) | (ifid_uses_rm & idex_rd == ifid_rm)).
  - Register 31 (XZR) never creates a hazard.
- stall_pc = stall_ifid = (lu_hazard & ~flush) | hold.
- Register update on each posedge, priority highest first:
  1. reset: load zeros.
  2. flush: load bubble. Bubble = valid=0, all five control bits 0, aluop=0. rn/rm/rd/data are don't-care; they are driven to 0.
  3. hold: all idex_* keep their values; stall_count unchanged.
  4. lu_hazard: load bubble; stall_count increments, saturating at 2^CNT_W-1.
  5. Otherwise load all ifid_* fields. If ifid_valid=0, load a bubble instead (controls forced 0).
- Latency: one cycle from ifid_* to idex_*.
- A load-use stall lasts exactly one cycle. The bubble clears idex_memread, so lu_hazard drops on the next cycle and the held instruction then enters ID/EX. Back-to-back loads with a dependency each produce one separate bubble.
- flush and lu_hazard together: flush wins, no stall, counter not incremented.
- flush and hold together: flush wins, bubble loaded. stall_pc/stall_ifid still = 1 because of hold.
- Reset during a stall: the next cycle has idex_valid=0, so no hazard; stall outputs drop.
- All idex_* outputs are register outputs, with no combinational path from ifid_*. stall_* are combinational from idex_* and ifid_*, plus flush and hold.

Test Plan:
- Reset: hold reset 2 cycles with random ifid inputs -> all idex_* = 0, stall_count = 0, stall_pc = 0.
- Pass-through: ADD rd=3, rn=1, rm=2, opa=5, opb=7, regwrite=1, aluop=3'b010 -> next cycle idex_rd=3, idex_opa=5, idex_opb=7, idex_regwrite=1, stall_pc=0.
- Load-use on rm:
  - Stimulus: LDUR X4 in ID/EX (memread=1, rd=4), then ADD rn=1, rm=4, uses_rm=1 in ID.
  - Response: stall_pc = stall_ifid = 1 for exactly 1 cycle; next idex_valid=0 with controls 0; stall_count=1. The cycle after, ADD appears with idex_rm=4.
- No false hazards:
  - LDUR rd=31 followed by an instruction with rn=31 -> no stall.
  - LDUR rd=4 followed by ADDI rn=1 with rm field=4 and uses_rm=0 -> no stall.
- Flush priority: load-use hazard plus flush=1 in the same cycle -> stall_pc=0, idex_valid=0, stall_count unchanged.
- Hold and saturation:
  - hold=1 for 3 cycles -> idex_* unchanged and stall_pc=1 throughout.
  - With CNT_W=2, 5 load-use events -> stall_count stops at 3.
